ialu_dispatch_ctrl: RTL
=======================

// Module: ialu_dispatch_ctrl
// PURPOSE
//  Sequential successor to the IALU unit decoder. Accepts one integer-ALU op per handshake and drives registered one-hot unit enables.
//  Single-cycle units get a 1-cycle enable pulse. Multi-cycle units (MUL/DIV) have their enable held until they report done, while upstream is stalled.
//  Sits between the issue stage and the IALU unit bank; adds watchdog timeout, flush and an issue counter.
// PARAMETERS
//  NUM_UNITS    8            unit-enable vector width; code NUM_UNITS-1 is IDLE/illegal
//  SEL_W        $clog2(NUM_UNITS)  width of IALU_Ctrl
//  MULTI_MASK   8'b0000_0110 bit k=1: unit k is multi-cycle (MUL=1, DIV=2)
//  BRANCH_CODE  6            op code that also enables ADD_UNIT (address calc)
//  ADD_UNIT     0            unit index paired with BRANCH_CODE
//  TIMEOUT_CYC  64           max WAIT cycles before abort; range 1..2**16-1
//  CNT_W        16           issue_count width
// PORTS
//  CLK          in   1          clock, rising edge
//  rst_n        in   1          synchronous reset, active low
//  issue_valid  in   1          op present on IALU_Ctrl
//  IALU_Ctrl    in   SEL_W      unit select code
//  issue_ready  out  1          block can accept an op this cycle
//  flush        in   1          abandon current/incoming op
//  unit_done    in   NUM_UNITS  per-unit completion pulse (multi-cycle units)
//  unit_en      out  NUM_UNITS  registered one-hot enables (two bits set for branch)
//  busy         out  1          1 while in WAIT
//  illegal_op   out  1          1-cycle pulse: IDLE code accepted
//  timeout_err  out  1          1-cycle pulse: WAIT aborted by watchdog
//  issue_count  out  CNT_W      number of enables issued, wraps at 2**CNT_W
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state=IDLE, unit_en=0, busy=0, illegal_op=0, timeout_err=0, issue_count=0, watchdog=0.
//   Reset overrides every other input, including in WAIT.
//  issue_ready = (state==IDLE) & ~flush; combinational. Accept = issue_valid & issue_ready.
//  Decode: code k<NUM_UNITS-1 -> bit k; code BRANCH_CODE -> bits BRANCH_CODE and ADD_UNIT; code NUM_UNITS-1 -> none.
//  All outputs are registered; latency from accept edge to unit_en is 1 cycle.
//  IDLE:
//   - Accept of a legal single-cycle code: unit_en=decode for exactly 1 cycle, then 0 unless another accept.
//     Stay IDLE; back-to-back accepts give back-to-back pulses, one per cycle.
//   - Accept of a legal multi-cycle code (MULTI_MASK bit set): unit_en=decode and held; go to WAIT; busy=1; watchdog=0.
//   - Accept of code NUM_UNITS-1: no enable, illegal_op pulses 1 cycle, no count.
//   - No accept: unit_en=0.
//  WAIT (issue_ready=0):
//   - Wait for unit_done[active]; unit_done bits of other units are ignored.
//   - On unit_done[active]: unit_en=0 and busy=0 next cycle; state=IDLE, so issue_ready=1 in that same next cycle.
//   - Watchdog increments every WAIT cycle without done. When it reaches TIMEOUT_CYC-1 without done:
//     next cycle unit_en=0, busy=0, timeout_err pulses 1 cycle, state=IDLE.
//   - done and timeout in the same cycle: done wins, no timeout_err.
//  flush priority: rst_n > flush > done > timeout > issue.
//   - flush in IDLE blocks the accept (issue_ready=0) and clears unit_en next cycle.
//   - flush in WAIT: unit_en=0, busy=0, state=IDLE next cycle, no error pulse.
//  issue_count += 1 on every legal accept (branch counts once); wraps 2**CNT_W-1 -> 0 without error.
//  unit_en is never 0 while busy=1; at most one multi-cycle op is in flight.
// TESTING
//  1 Reset: hold rst_n=0 3 cycles with issue_valid=1, code 0 -> all outputs 0; first op accepted only after rst_n=1.
//  2 Back-to-back: codes 0,3,4,5,6 on consecutive cycles ->
//    unit_en 01,08,10,20,41 on the following cycles; issue_ready stays 1; issue_count=5.
//  3 MUL: code 1, then unit_done[1] 4 cycles later -> unit_en=02 and busy=1 until the cycle after done; issue_ready=0 throughout.
//    unit_done[2] pulsed mid-wait is ignored.
//  4 DIV timeout (TIMEOUT_CYC=8): code 2, no done -> timeout_err pulses 8 cycles after entering WAIT; unit_en=0; next op accepted.
//  5 Code 7 -> illegal_op 1-cycle pulse, unit_en=0, count unchanged.
//    flush during WAIT -> IDLE next cycle, no error pulse.
//    flush together with issue_valid in IDLE -> op not accepted.
//  6 Wrap (CNT_W=4): 17 legal accepts -> issue_count=1.

Source files
------------

// File: rtl/ialu_dispatch_ctrl.sv
// ialu_dispatch_ctrl
//   Sequential dispatch controller for the integer-ALU unit bank. It accepts
//   one op per handshake and drives registered one-hot unit enables.
//   Single-cycle units receive a one-cycle enable pulse. Multi-cycle units
//   (MUL/DIV) keep their enable asserted until they report done, and issue is
//   stalled for that time. A watchdog aborts a multi-cycle op that never
//   completes. A flush abandons the current op or the incoming op. The
//   controller also counts every enable it issues.
//
// Handshake: an op transfers on a rising CLK edge where issue_valid and
//   issue_ready are both 1. issue_ready is combinational, and it is 1 only in
//   IDLE with flush low. issue_valid may stay high while issue_ready is 0; the
//   op is then held off and is not lost.
//
// Ports
//   CLK          in   clock, rising edge
//   rst_n        in   synchronous reset, active low, overrides everything
//   issue_valid  in   op present on IALU_Ctrl
//   IALU_Ctrl    in   unit select code (NUM_UNITS-1 = IDLE/illegal)
//   issue_ready  out  block can accept an op this cycle
//   flush        in   abandon current / incoming op
//   unit_done    in   per-unit completion pulse (multi-cycle units)
//   unit_en      out  registered one-hot enables (two bits for branch)
//   busy         out  1 while waiting on a multi-cycle unit
//   illegal_op   out  1-cycle pulse: illegal/IDLE code accepted
//   timeout_err  out  1-cycle pulse: wait aborted by watchdog
//   issue_count  out  number of legal ops issued, wrapping
//   fsm_state    out  current FSM state (0 = IDLE, 1 = WAIT), for debug
module ialu_dispatch_ctrl #(
  parameter int                   NUM_UNITS   = 8,
  parameter int                   SEL_W       = $clog2(NUM_UNITS),
  parameter logic [NUM_UNITS-1:0] MULTI_MASK  = 8'b0000_0110,
  parameter int                   BRANCH_CODE = 6,
  parameter int                   ADD_UNIT    = 0,
  parameter int                   TIMEOUT_CYC = 64,
  parameter int                   CNT_W       = 16
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  input  logic [SEL_W-1:0]     IALU_Ctrl,
  output logic                 issue_ready,
  input  logic                 flush,
  input  logic [NUM_UNITS-1:0] unit_done,
  output logic [NUM_UNITS-1:0] unit_en,
  output logic                 busy,
  output logic                 illegal_op,
  output logic                 timeout_err,
  output logic [CNT_W-1:0]     issue_count,
  output logic                 fsm_state
);

  localparam int WD_W = 16;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_UNITS-1:0]   en_q, en_d;
  logic                   busy_q, busy_d;
  logic                   ill_q, ill_d;
  logic                   to_q, to_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WD_W-1:0]        wd_q, wd_d;

  logic [NUM_UNITS-1:0]   decoded;
  logic                   legal;
  logic                   is_multi;
  logic                   accept;
  logic                   done_hit;
  logic                   wd_expired;

  // Decode. The top code and any unused encodings above it select no unit.
  // The branch code also fires the adder, which does the address calculation.
  always_comb begin
    decoded = '0;
    legal   = (int'(IALU_Ctrl) < NUM_UNITS - 1);
    if (legal) begin
      decoded[IALU_Ctrl] = 1'b1;
      if (int'(IALU_Ctrl) == BRANCH_CODE) decoded[ADD_UNIT] = 1'b1;
    end
  end

  assign is_multi    = |(decoded & MULTI_MASK);
  assign issue_ready = (state_q == S_IDLE) && !flush;
  assign accept      = issue_valid && issue_ready;

  // Only the done pulse of the unit being waited on ends the wait. In WAIT,
  // en_q holds exactly the active multi-cycle unit.
  assign done_hit    = |(en_q & unit_done & MULTI_MASK);
  assign wd_expired  = (wd_q == WD_W'(TIMEOUT_CYC - 1));

  // State register. All outputs are registered alongside the state.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      en_q    <= '0;
      busy_q  <= 1'b0;
      ill_q   <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      ill_q   <= ill_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
    end
  end

  // Next-state logic. Priority inside WAIT: flush > done > timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept && legal && is_multi) state_d = S_WAIT;
      S_WAIT: if (flush || done_hit || wd_expired) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs. Pulses default low.
  always_comb begin
    en_d   = '0;
    busy_d = 1'b0;
    ill_d  = 1'b0;
    to_d   = 1'b0;
    cnt_d  = cnt_q;
    wd_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (legal) begin
            en_d   = decoded;
            busy_d = is_multi;
            cnt_d  = cnt_q + 1'b1;
          end else begin
            ill_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (flush || done_hit) begin
          // Drop back to IDLE quietly; the defaults already clear everything.
        end else if (wd_expired) begin
          to_d = 1'b1;
        end else begin
          en_d   = en_q;
          busy_d = 1'b1;
          wd_d   = wd_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign unit_en     = en_q;
  assign busy        = busy_q;
  assign illegal_op  = ill_q;
  assign timeout_err = to_q;
  assign issue_count = cnt_q;
  assign fsm_state   = state_q;

endmodule
